// File: rtl/program_writer.sv
// Instruction encoder and 256x16 program memory.
// Encodes register/immediate forms, writes sequentially, fetches by PC.
module program_writer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [3:0]  selWrite,
  input  logic [3:0]  selA,
  input  logic [3:0]  selB,
  input  logic [7:0]  immediate,
  input  logic        use_imm8,
  input  logic [7:0]  PC,
  output logic [15:0] instruction,
  output logic [7:0]  write_addr,
  output logic [8:0]  instr_count,
  output logic        full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] word;
  logic [15:0] enc;
  logic [15:0] mem [256];
  logic        wr_en;

  assign enc = use_imm8 ? {opcode, selWrite, immediate}
                        : {opcode, selWrite, selA, selB};

  // Reset and clear both cancel a pending word.
  assign wr_en = (state == WRITE) && !reset && !clear;

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[write_addr] <= word;
  end

  always_ff @(posedge clock) begin
    if (reset)
      instruction <= 16'h0000;
    else
      instruction <= mem[PC];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      word        <= 16'h0000;
      write_addr  <= 8'd0;
      instr_count <= 9'd0;
      full        <= 1'b0;
      in_ready    <= 1'b1;
    end else if (clear) begin
      state       <= IDLE;
      write_addr  <= 8'd0;
      instr_count <= 9'd0;
      full        <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word     <= enc;
            state    <= WRITE;
            in_ready <= 1'b0;
          end
        end
        WRITE: begin
          write_addr  <= write_addr + 8'd1;
          instr_count <= instr_count + 9'd1;
          if (instr_count == 9'd255) begin
            state    <= FULL;
            full     <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        FULL: begin
          in_ready <= 1'b0;
          full     <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_writer.sv
// Bench for program_writer: directed scenarios plus random traffic
// against a count/array reference model.
module tb_program_writer;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  selWrite;
  logic [3:0]  selA;
  logic [3:0]  selB;
  logic [7:0]  immediate;
  logic        use_imm8;
  logic [7:0]  PC;
  logic [15:0] instruction;
  logic [7:0]  write_addr;
  logic [8:0]  instr_count;
  logic        full;

  int errors = 0;
  int checks = 0;

  program_writer dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .selWrite(selWrite), .selA(selA),
    .selB(selB), .immediate(immediate), .use_imm8(use_imm8),
    .PC(PC), .instruction(instruction), .write_addr(write_addr),
    .instr_count(instr_count), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model
  logic [15:0] mem_m [256];
  bit          known_m [256];
  int          cnt_m;
  bit          pend_m;
  logic [15:0] pend_word;
  logic [15:0] exp_instr;
  bit          exp_known;

  function automatic logic [15:0] encode();
    if (use_imm8) return {opcode, selWrite, immediate};
    return {opcode, selWrite, selA, selB};
  endfunction

  function automatic bit ready_m();
    return !pend_m && (cnt_m < 256);
  endfunction

  task automatic tick();
    exp_instr = mem_m[PC];
    exp_known = known_m[PC];
    if (reset) begin
      cnt_m = 0; pend_m = 0;
      exp_instr = 16'h0000; exp_known = 1;
    end else if (clear) begin
      cnt_m = 0; pend_m = 0;
    end else if (pend_m) begin
      mem_m[cnt_m % 256] = pend_word;
      known_m[cnt_m % 256] = 1;
      cnt_m++;
      pend_m = 0;
    end else if (cnt_m < 256 && in_valid) begin
      pend_m = 1;
      pend_word = encode();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_fields();
    opcode    = 4'($urandom);
    selWrite  = 4'($urandom);
    selA      = 4'($urandom);
    selB      = 4'($urandom);
    immediate = 8'($urandom);
    use_imm8  = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1; clear = 0; in_valid = 0; PC = 0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b full=%b want 1 0", in_ready, full);
    end
    checks++;
    if (instr_count !== 9'd0 || write_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: cnt=%0d wa=%0d want 0 0", instr_count, write_addr);
    end
    checks++;
    if (instruction !== 16'h0000) begin
      errors++;
      $display("FAIL reset_instr: got %h want 0000", instruction);
    end
    reset = 0;
  endtask

  task automatic test_reg_form();
    opcode = 4'h6; selWrite = 4'hC; selA = 4'hE; selB = 4'h3;
    immediate = 8'h55; use_imm8 = 0; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    PC = 0;
    tick();
    checks++;
    if (instruction !== 16'h6CE3) begin
      errors++;
      $display("FAIL reg_form: got %h want 6ce3", instruction);
    end
    checks++;
    if (write_addr !== 8'd1 || instr_count !== 9'd1) begin
      errors++;
      $display("FAIL reg_counts: wa=%0d cnt=%0d want 1 1", write_addr, instr_count);
    end
  endtask

  task automatic test_imm_form();
    opcode = 4'h9; selWrite = 4'hA; immediate = 8'hF8;
    selA = 4'($urandom); selB = 4'($urandom); use_imm8 = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    PC = 1;
    tick();
    checks++;
    if (instruction !== 16'h9AF8) begin
      errors++;
      $display("FAIL imm_form: got %h want 9af8", instruction);
    end
  endtask

  task automatic test_throughput();
    int acc;
    clear = 1; tick(); clear = 0;
    acc = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      randomize_fields();
      checks++;
      if (in_ready !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL ready_toggle[%0d]: got %b want %b", i, in_ready, (i % 2) == 0);
      end
      if (in_ready === 1'b1) acc++;
      tick();
    end
    in_valid = 0;
    checks++;
    if (acc != 5 || instr_count !== 9'd5) begin
      errors++;
      $display("FAIL throughput: accepts=%0d cnt=%0d want 5 5", acc, instr_count);
    end
  endtask

  task automatic test_full();
    logic [15:0] m0;
    clear = 1; tick(); clear = 0;
    in_valid = 1;
    for (int i = 0; i < 520 && cnt_m < 256; i++) begin
      randomize_fields();
      tick();
    end
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flags: full=%b ready=%b want 1 0", full, in_ready);
    end
    checks++;
    if (write_addr !== 8'd0 || instr_count !== 9'd256) begin
      errors++;
      $display("FAIL full_counts: wa=%0d cnt=%0d want 0 256", write_addr, instr_count);
    end
    for (int i = 0; i < 4; i++) begin
      randomize_fields();
      tick();
    end
    checks++;
    if (instr_count !== 9'd256 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: cnt=%0d full=%b want 256 1", instr_count, full);
    end
    in_valid = 0;
    m0 = mem_m[0];
    clear = 1; PC = 0; tick(); clear = 0;
    checks++;
    if (instr_count !== 9'd0 || in_ready !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_clear: cnt=%0d ready=%b full=%b want 0 1 0",
               instr_count, in_ready, full);
    end
    tick();
    checks++;
    if (instruction !== m0) begin
      errors++;
      $display("FAIL mem_kept: got %h want %h", instruction, m0);
    end
  endtask

  task automatic test_clear_cases();
    randomize_fields();
    clear = 1; in_valid = 1; tick();
    clear = 0; in_valid = 0; tick();
    checks++;
    if (instr_count !== 9'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_idle: cnt=%0d ready=%b want 0 1", instr_count, in_ready);
    end
    PC = 0;
    opcode = ~mem_m[0][15:12]; use_imm8 = 0;
    in_valid = 1; tick();
    in_valid = 0; clear = 1; tick();
    clear = 0;
    checks++;
    if (write_addr !== 8'd0 || instr_count !== 9'd0) begin
      errors++;
      $display("FAIL clear_write: wa=%0d cnt=%0d want 0 0", write_addr, instr_count);
    end
    tick();
    checks++;
    if (instruction !== mem_m[0]) begin
      errors++;
      $display("FAIL clear_discard: got %h want %h", instruction, mem_m[0]);
    end
  endtask

  task automatic test_same_addr();
    logic [15:0] old_w;
    logic [15:0] new_w;
    old_w = mem_m[0];
    randomize_fields();
    opcode = ~old_w[15:12];
    new_w = encode();
    in_valid = 1; tick();
    in_valid = 0; PC = 8'(cnt_m); tick();
    checks++;
    if (instruction !== old_w) begin
      errors++;
      $display("FAIL same_addr_old: got %h want %h", instruction, old_w);
    end
    tick();
    checks++;
    if (instruction !== new_w) begin
      errors++;
      $display("FAIL same_addr_new: got %h want %h", instruction, new_w);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_fields();
      in_valid = 1'($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 49) == 0);
      PC = ($urandom_range(0, 1) == 0) ? 8'(cnt_m) : 8'($urandom);
      tick();
      checks++;
      if (in_ready !== ready_m() || full !== (cnt_m == 256) ||
          instr_count !== 9'(cnt_m) || write_addr !== 8'(cnt_m)) begin
        errors++;
        $display("FAIL rand_state[%0d]: rdy=%b full=%b cnt=%0d wa=%0d want %b %b %0d %0d",
                 i, in_ready, full, instr_count, write_addr,
                 ready_m(), cnt_m == 256, cnt_m, 8'(cnt_m));
      end
      if (exp_known) begin
        checks++;
        if (instruction !== exp_instr) begin
          errors++;
          $display("FAIL rand_instr[%0d]: got %h want %h", i, instruction, exp_instr);
        end
      end
    end
    reset = 0; clear = 0; in_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 16'h0000;
      known_m[i] = 0;
    end
    cnt_m = 0; pend_m = 0; pend_word = 0;
    exp_instr = 0; exp_known = 0;
    reset = 1; clear = 0; in_valid = 0; PC = 0;
    opcode = 0; selWrite = 0; selA = 0; selB = 0;
    immediate = 0; use_imm8 = 0;
    test_reset();
    test_reg_form();
    test_imm_form();
    test_throughput();
    test_full();
    test_clear_cases();
    test_same_addr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
